edge_period_meter: RTL
======================

Name: edge_period_meter

Overview:
Measures the spacing of edges on a slow toggling input, counted in system clock cycles. It does the reverse of our clock/LED dividers: a divider turns the clock into a toggle, and this block turns a toggle back into a cycle count. It reports every half-period, flags timeouts, and declares lock once successive measurements agree. It sits beside the divider outputs and external square-wave inputs for self-check and frequency readback.

Parameters:
CNT_W, 16, width of the period counter and the period output
SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2)
LOCK_N, 4, consecutive in-tolerance comparisons required to assert locked (minimum 1)
TOL, 1, maximum absolute difference in cycles between consecutive measurements that still counts as a match

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  measurement enable, synchronous
sig_in  input  1  asynchronous toggling input to be measured
period  output  CNT_W  last captured edge-to-edge spacing in clk cycles
period_valid  output  1  one-cycle pulse when period updates
overflow  output  1  sticky; no edge seen within 2^CNT_W-1 cycles
locked  output  1  measurements stable within TOL

Behaviour:
Reset (async, rst=1):
- All flops clear: period=0, period_valid=0, overflow=0, locked=0.
- Synchronizer=0, run_cnt=0, match_cnt=0, state=IDLE.
- Reset mid-measurement discards all partial state.

Synchronizer and edge detect:
- sig_in passes through SYNC_STAGES flops, then one history flop.
- edge = sync_out XOR history, so both rising and falling edges count.
- Latency from a sig_in transition to edge: SYNC_STAGES+1 cycles.

States:
- IDLE: en=0. run_cnt=0, match_cnt=0, locked=0, overflow=0. period holds its value. go ARM when en=1.
- ARM: wait for the first edge. On edge: run_cnt<=1, go MEAS. No period_valid. The first edge after enable is never measured.
- MEAS:
  - Each cycle without an edge: run_cnt<=run_cnt+1.
  - On edge: period<=run_cnt, period_valid<=1 (next cycle, one cycle only), run_cnt<=1.
  - Edges at cycles a and b give period=b-a.
- en=0 in any state: go IDLE next cycle. A simultaneous edge is ignored, with no period_valid.

Timeout:
- In MEAS, if run_cnt == 2^CNT_W-1 and there is no edge that cycle: overflow<=1 (sticky), locked<=0, match_cnt<=0, go ARM. No period_valid.
- An edge in that same cycle is a normal capture with period=2^CNT_W-1, and no overflow.
- overflow clears only on rst or by passing through IDLE.

Lock (evaluated on each capture):
- prev holds the previous captured value and is invalid after IDLE or ARM.
- First capture after ARM: prev<=value, match_cnt stays 0.
- Later captures with |value-prev| <= TOL: match_cnt increments, saturating at LOCK_N. When it reaches LOCK_N, locked<=1, updated in the same cycle as period_valid.
- Later captures with |value-prev| > TOL: match_cnt<=0, locked<=0.
- prev<=value on every capture.
- Difference arithmetic uses CNT_W+1 bits, with no wrap.
- Result: lock first asserts on capture number LOCK_N+1 after ARM.

Register rules:
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Lock on a steady toggle:
   - Stimulus: en=1; sig_in toggles every 6 clk cycles (a divide-by-12 LED).
   - Response: period_valid pulses every 6 cycles with period=6; the first pulse follows the second toggle.
   - Response: locked=1 coincident with the 5th period_valid (LOCK_N=4).
2. Jitter within and beyond tolerance:
   - Stimulus: after lock, edge spacings 6,7,6,5 with TOL=1.
   - Response: locked stays 1.
   - Stimulus: then a spacing of 9.
   - Response: period=9 and locked=0 in the same cycle; re-lock after 4 further spacings of 9.
3. Timeout:
   - Stimulus: CNT_W=4; in MEAS, hold sig_in static for 20 cycles.
   - Response: overflow=1 exactly 15 cycles after the last edge, locked=0, no period_valid.
   - Stimulus: resume toggling.
   - Response: first edge re-arms only; overflow remains 1.
4. Edge at saturation:
   - Stimulus: CNT_W=4; edges exactly 15 cycles apart.
   - Response: period=15 and period_valid on every capture; overflow stays 0.
5. Enable deassertion:
   - Stimulus: drop en mid-period while locked and overflow=1.
   - Response: next cycle overflow=0 and locked=0; period holds its last value.
   - Stimulus: re-assert en.
   - Response: first edge gives no period_valid.
6. Async reset mid-operation:
   - Stimulus: assert rst between clock edges during MEAS.
   - Response: period=0, locked=0, overflow=0 immediately, without waiting for a clock.
   - Stimulus: release rst and toggle every 6 cycles.
   - Response: the first capture after release is period=6.

Source files
------------

// File: rtl/edge_period_meter.sv
// edge_period_meter: measures edge-to-edge spacing of a slow toggling input in clk cycles, with timeout and lock detection
module edge_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_N      = 4,
   parameter int TOL         = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             overflow,
   output logic             locked
);
   localparam int M_W = $clog2(LOCK_N + 1);
   localparam logic [M_W-1:0] LOCK_V = M_W'(LOCK_N);
   localparam logic [M_W-1:0] LOCK_M1 = M_W'(LOCK_N - 1);
   localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);
   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sync;
   logic hist;
   logic edge_det;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] prev;
   logic prev_ok;
   logic [M_W-1:0] match_cnt;
   logic [CNT_W:0] diff;
   logic close;
   assign edge_det = sync[SYNC_STAGES-1] ^ hist;
   // distance between the fresh measurement and the previous one, one extra bit so it never wraps
   always_comb begin
      diff = (run_cnt >= prev) ? {1'b0, run_cnt} - {1'b0, prev} : {1'b0, prev} - {1'b0, run_cnt};
      close = diff <= TOL_V;
   end
   // bring sig_in into the clk domain and keep one history bit for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         hist <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sig_in};
         hist <= sync[SYNC_STAGES-1];
      end
   end
   // measurement FSM: arm on the first edge, capture spacing on later edges, time out at counter saturation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         run_cnt      <= '0;
         prev         <= '0;
         prev_ok      <= 1'b0;
         match_cnt    <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
         locked       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!en) begin
            state     <= IDLE;
            run_cnt   <= '0;
            prev_ok   <= 1'b0;
            match_cnt <= '0;
            overflow  <= 1'b0;
            locked    <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM: begin
                  if (edge_det) begin
                     run_cnt <= CNT_W'(1);
                     state   <= MEAS;
                  end
               end
               MEAS: begin
                  if (edge_det) begin
                     period       <= run_cnt;
                     period_valid <= 1'b1;
                     run_cnt      <= CNT_W'(1);
                     prev         <= run_cnt;
                     prev_ok      <= 1'b1;
                     if (prev_ok && close) begin
                        match_cnt <= (match_cnt == LOCK_V) ? match_cnt : match_cnt + 1'b1;
                        if (match_cnt >= LOCK_M1) locked <= 1'b1;
                     end else if (prev_ok) begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                     end
                  end else if (&run_cnt) begin
                     overflow  <= 1'b1;
                     locked    <= 1'b0;
                     match_cnt <= '0;
                     prev_ok   <= 1'b0;
                     state     <= ARM;
                  end else begin
                     run_cnt <= run_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
